// File: rtl/pwm_seq_pkg.sv
// Shared types, AXI constants and the ramp arithmetic for the PWM fade sequencer.
package pwm_seq_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    RESP
  } fsm_state_t;

  // Next duty one step toward tgt; lands exactly on tgt and never wraps.
  function automatic logic [31:0] ramp_next(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [31:0] step);
    logic [31:0] diff;
    logic [31:0] res;
    res = tgt;
    if (step != '0 && cur != tgt) begin
      if (cur < tgt) begin
        diff = tgt - cur;
        res  = (diff <= step) ? tgt : cur + step;
      end else begin
        diff = cur - tgt;
        res  = (diff <= step) ? tgt : cur - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running prescaler: pulses tick_o for one cycle every TICK_DIV clocks.
module pwm_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// AXI4-Lite write master that ramps each massive_pwm duty register toward its
// software target, one step per prescaled tick.
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DUTY_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TICK_DIV  = 50000,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [DUTY_W-1:0]     cfg_target,
  input  logic [DUTY_W-1:0]     cfg_step,
  output logic                  busy,
  output logic                  err,
  output logic                  tick_overrun,
  input  logic                  sticky_clr,
  output logic [AXI_ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [AXI_DATA_W-1:0] M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  fsm_state_t state_q;

  logic [CH_W-1:0]       ch_q;
  logic [DUTY_W-1:0]     cur_q  [N_CH];
  logic [DUTY_W-1:0]     tgt_q  [N_CH];
  logic [DUTY_W-1:0]     step_q [N_CH];
  logic [DUTY_W-1:0]     nxt_q;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  overrun_q;
  logic                  pending_q;
  logic                  aw_done_q;
  logic                  w_done_q;

  logic                  tick;
  logic [DUTY_W-1:0]     cur_sel;
  logic [DUTY_W-1:0]     tgt_sel;
  logic [DUTY_W-1:0]     step_sel;
  logic [DUTY_W-1:0]     ramp_sel;
  logic                  ch_last;
  logic                  cfg_hit;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_done;
  logic                  w_done;

  pwm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i (ACLK),
    .rst_ni(ARESETN),
    .tick_o(tick)
  );

  always_comb begin
    cur_sel  = cur_q[ch_q];
    tgt_sel  = tgt_q[ch_q];
    step_sel = step_q[ch_q];
    ramp_sel = DUTY_W'(ramp_next(32'(cur_sel), 32'(tgt_sel), 32'(step_sel)));
  end

  assign ch_last = (ch_q == CH_W'(N_CH - 1));
  assign cfg_hit = cfg_we && (32'(cfg_ch) < N_CH);
  assign aw_hs   = awvalid_q & M_AXI_AWREADY;
  assign w_hs    = wvalid_q & M_AXI_WREADY;
  assign aw_done = aw_done_q | aw_hs;
  assign w_done  = w_done_q | w_hs;

  // Targets and steps may change at any time; an in-flight write keeps nxt_q.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int c = 0; c < N_CH; c++) begin
        tgt_q[c]  <= '0;
        step_q[c] <= '0;
      end
    end else if (cfg_hit) begin
      tgt_q[cfg_ch]  <= cfg_target;
      step_q[cfg_ch] <= cfg_step;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      nxt_q     <= '0;
      addr_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        cur_q[c] <= '0;
      end
    end else begin
      // Clear first so a same-cycle sticky event below takes precedence.
      if (sticky_clr) begin
        err_q     <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (tick && (state_q != IDLE)) begin
        if (pending_q) begin
          overrun_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (tick || pending_q) begin
            state_q   <= SCAN;
            busy_q    <= 1'b1;
            ch_q      <= '0;
            pending_q <= 1'b0;
          end
        end
        SCAN: begin
          if (cur_sel == tgt_sel) begin
            if (ch_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end else begin
            nxt_q     <= ramp_sel;
            addr_q    <= BASE_ADDR + (AXI_ADDR_W'(ch_q) << 2);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_done && w_done) begin
            state_q  <= RESP;
            bready_q <= 1'b1;
          end
        end
        RESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            // A failed write leaves cur untouched so the next scan retries it.
            if (M_AXI_BRESP == RESP_OKAY) begin
              cur_q[ch_q] <= nxt_q;
            end else begin
              err_q <= 1'b1;
            end
            if (ch_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ch_q    <= ch_q + 1'b1;
              state_q <= SCAN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign err           = err_q;
  assign tick_overrun  = overrun_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = AXI_DATA_W'(nxt_q);
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer with a configurable AXI4-Lite slave model.
module tb_pwm_fade_sequencer;

  localparam int unsigned N_CH = 4;
  localparam int unsigned DUTY_W = 16;
  localparam int unsigned TDIV = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_target;
  logic [15:0] cfg_step;
  logic        sticky_clr;
  logic        busy, err, tick_overrun;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  bresp;

  int vec_n = 0;
  int miss_n = 0;
  int cyc = 0;

  // Slave configuration (written only by the test sequence)
  int aw_lat = 0;
  int w_lat = 0;
  int b_lat = 0;
  logic [1:0] bresp_cfg = 2'b00;

  // Slave state and transaction log (written only by the slave process)
  logic aw_got, w_got;
  int aw_cnt, w_cnt, b_cnt;
  logic [31:0] aw_addr_l, w_data_l;
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [1:0]  log_resp [64];
  int          log_cyc  [64];
  int log_n = 0;
  int aw_hs_n = 0;

  pwm_fade_sequencer #(
    .N_CH     (N_CH),
    .DUTY_W   (DUTY_W),
    .BASE_ADDR(BASE),
    .TICK_DIV (TDIV)
  ) dut (
    .ACLK         (clk),
    .ARESETN      (rst_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_target   (cfg_target),
    .cfg_step     (cfg_step),
    .busy         (busy),
    .err          (err),
    .tick_overrun (tick_overrun),
    .sticky_clr   (sticky_clr),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave decides at each negedge what the following posedge will handshake.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_addr_l = '0; w_data_l = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        if (bvalid) begin
          bvalid = 1'b0; bresp = 2'b00;
          aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
        end else if (aw_got && w_got && bready) begin
          if (b_cnt >= b_lat) begin
            bvalid = 1'b1;
            bresp  = bresp_cfg;
            if (log_n < 64) begin
              log_addr[log_n] = aw_addr_l;
              log_data[log_n] = w_data_l;
              log_resp[log_n] = bresp_cfg;
              log_cyc[log_n]  = cyc;
              log_n++;
            end
          end else begin
            b_cnt++;
          end
        end
        awready = 1'b0;
        wready  = 1'b0;
        if (awvalid && !aw_got) begin
          if (aw_cnt >= aw_lat) begin
            awready = 1'b1; aw_got = 1'b1; aw_addr_l = awaddr; aw_hs_n++; aw_cnt = 0;
          end else begin
            aw_cnt++;
          end
        end
        if (wvalid && !w_got) begin
          if (w_cnt >= w_lat) begin
            wready = 1'b1; w_got = 1'b1; w_data_l = wdata; w_cnt = 0;
          end else begin
            w_cnt++;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int tgt, input int stp);
    cfg_we = 1'b1; cfg_ch = ch[1:0]; cfg_target = tgt[15:0]; cfg_step = stp[15:0];
    step();
    cfg_we = 1'b0;
  endtask

  // Returns just after a scan has finished, so the next tick is far away.
  task automatic sync_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 60) begin step(); n++; end
    while (busy !== 1'b0 && n < 400) begin step(); n++; end
    vec_n++;
    if (busy !== 1'b0) begin
      miss_n++;
      $display("FAIL %s sync: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic wait_log(input string tag, input int target, input int limit);
    int n;
    n = 0;
    while (log_n < target && n < limit) begin step(); n++; end
    vec_n++;
    if (log_n < target) begin
      miss_n++;
      $display("FAIL %s wait: writes=%0d, required %0d", tag, log_n, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_target = '0; cfg_step = '0;
    sticky_clr = 1'b0;
    repeat (3) step();
    vec_n++;
    if ({busy, err, tick_overrun, awvalid, wvalid, bready} !== 6'b0) begin
      miss_n++;
      $display("FAIL reset_flags: got %b, required 000000",
               {busy, err, tick_overrun, awvalid, wvalid, bready});
    end
    vec_n++;
    if (awaddr !== 32'h0 || wdata !== 32'h0 || awprot !== 3'b000 || wstrb !== 4'hF) begin
      miss_n++;
      $display("FAIL reset_bus: addr=%h data=%h prot=%b strb=%h, required 0/0/000/F",
               awaddr, wdata, awprot, wstrb);
    end
    rst_n = 1'b1;
    repeat (4 * TDIV) step();
    vec_n++;
    if (log_n !== 0 || aw_hs_n !== 0) begin
      miss_n++;
      $display("FAIL reset_idle_writes: got %0d/%0d, required 0", log_n, aw_hs_n);
    end
  endtask

  task automatic test_ramp_up();
    int base;
    int exp_d [3];
    int hi;
    exp_d = '{4, 8, 10};
    sync_idle("ramp");
    base = log_n;
    cfg(1, 10, 4);
    wait_log("ramp", base + 3, 6 * TDIV);
    for (int i = 0; i < 3; i++) begin
      vec_n++;
      if (log_addr[base+i] !== BASE + 32'd4 || log_data[base+i] !== 32'(exp_d[i])) begin
        miss_n++;
        $display("FAIL ramp_write%0d: got %h/%0d, required %h/%0d", i,
                 log_addr[base+i], log_data[base+i], BASE + 32'd4, exp_d[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      vec_n++;
      if (log_cyc[base+i] - log_cyc[base+i-1] !== TDIV) begin
        miss_n++;
        $display("FAIL ramp_spacing%0d: got %0d cycles, required %0d", i,
                 log_cyc[base+i] - log_cyc[base+i-1], TDIV);
      end
    end
    repeat (3 * TDIV) step();
    hi = 0;
    for (int i = 0; i < 2 * TDIV; i++) begin
      step();
      if (busy === 1'b1) hi++;
    end
    vec_n++;
    if (log_n !== base + 3 || hi !== 8) begin
      miss_n++;
      $display("FAIL ramp_settled: writes=%0d busy_cycles=%0d, required %0d/8",
               log_n - base, hi, 3);
    end
  endtask

  task automatic test_jump_down();
    int base;
    sync_idle("jump");
    base = log_n;
    cfg(1, 3, 0);
    wait_log("jump", base + 1, 3 * TDIV);
    vec_n++;
    if (log_addr[base] !== BASE + 32'd4 || log_data[base] !== 32'h0000_0003) begin
      miss_n++;
      $display("FAIL jump_write: got %h/%h, required %h/00000003",
               log_addr[base], log_data[base], BASE + 32'd4);
    end
    repeat (3 * TDIV) step();
    vec_n++;
    if (log_n !== base + 1) begin
      miss_n++;
      $display("FAIL jump_no_rewrite: writes=%0d, required 1", log_n - base);
    end
  endtask

  task automatic test_w_delay();
    int base, aw0, n, aw_hi, w_hi;
    logic bad;
    w_lat = 5;
    sync_idle("wdelay");
    base = log_n;
    aw0 = aw_hs_n;
    cfg(2, 7, 0);
    n = 0;
    while (awvalid !== 1'b1 && n < 3 * TDIV) begin step(); n++; end
    aw_hi = 0; w_hi = 0; bad = 1'b0; n = 0;
    while ((awvalid === 1'b1 || wvalid === 1'b1) && n < 40) begin
      if (awvalid === 1'b1) begin
        aw_hi++;
        if (awaddr !== BASE + 32'd8) bad = 1'b1;
      end
      if (wvalid === 1'b1) begin
        w_hi++;
        if (wdata !== 32'd7) bad = 1'b1;
      end
      step();
      n++;
    end
    w_lat = 0;
    vec_n++;
    if (aw_hi !== 1 || w_hi !== 6 || bad !== 1'b0) begin
      miss_n++;
      $display("FAIL wdelay_valid: awvalid=%0d wvalid=%0d cycles unstable=%b, required 1/6/0",
               aw_hi, w_hi, bad);
    end
    wait_log("wdelay", base + 1, 2 * TDIV);
    repeat (3 * TDIV) step();
    vec_n++;
    if (log_n !== base + 1 || aw_hs_n !== aw0 + 1 || log_data[base] !== 32'd7) begin
      miss_n++;
      $display("FAIL wdelay_once: b=%0d aw=%0d data=%0d, required 1/1/7",
               log_n - base, aw_hs_n - aw0, log_data[base]);
    end
  endtask

  task automatic test_bresp_err();
    int base;
    sync_idle("err");
    base = log_n;
    bresp_cfg = 2'b10;
    cfg(0, 5, 0);
    wait_log("err", base + 1, 3 * TDIV);
    bresp_cfg = 2'b00;
    step();
    vec_n++;
    if (err !== 1'b1 || log_data[base] !== 32'd5 || log_addr[base] !== BASE) begin
      miss_n++;
      $display("FAIL err_set: err=%b data=%0d addr=%h, required 1/5/%h",
               err, log_data[base], log_addr[base], BASE);
    end
    wait_log("err_retry", base + 2, 3 * TDIV);
    vec_n++;
    if (log_data[base+1] !== 32'd5 || log_addr[base+1] !== BASE ||
        log_cyc[base+1] - log_cyc[base] !== TDIV) begin
      miss_n++;
      $display("FAIL err_retry: data=%0d addr=%h gap=%0d, required 5/%h/%0d",
               log_data[base+1], log_addr[base+1], log_cyc[base+1] - log_cyc[base], BASE, TDIV);
    end
    vec_n++;
    if (err !== 1'b1) begin
      miss_n++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    vec_n++;
    if (err !== 1'b0) begin
      miss_n++;
      $display("FAIL err_clear: got %b, required 0", err);
    end
  endtask

  task automatic test_overrun();
    int base;
    int exp_d [4];
    logic [8:0] pat;
    exp_d = '{20, 30, 40, 50};
    vec_n++;
    if (tick_overrun !== 1'b0) begin
      miss_n++;
      $display("FAIL overrun_pre: got %b, required 0", tick_overrun);
    end
    sync_idle("overrun");
    base = log_n;
    b_lat = 44;
    cfg(0, 20, 0);
    cfg(1, 30, 0);
    cfg(2, 40, 0);
    cfg(3, 50, 0);
    wait_log("overrun_first", base + 1, 6 * TDIV);
    b_lat = 0;
    wait_log("overrun_all", base + 4, 2 * TDIV);
    pat = '0;
    for (int i = 0; i < 9; i++) begin
      step();
      pat = {pat[7:0], busy};
    end
    for (int i = 0; i < 4; i++) begin
      vec_n++;
      if (log_addr[base+i] !== BASE + 32'(4 * i) || log_data[base+i] !== 32'(exp_d[i])) begin
        miss_n++;
        $display("FAIL overrun_write%0d: got %h/%0d, required %h/%0d", i,
                 log_addr[base+i], log_data[base+i], BASE + 32'(4 * i), exp_d[i]);
      end
    end
    vec_n++;
    if (tick_overrun !== 1'b1) begin
      miss_n++;
      $display("FAIL overrun_flag: got %b, required 1", tick_overrun);
    end
    // IDLE, one pending-driven 4-cycle scan, idle until the next tick's scan.
    vec_n++;
    if (pat !== 9'b011110001) begin
      miss_n++;
      $display("FAIL overrun_extra_scan: busy pattern %b, required 011110001", pat);
    end
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    vec_n++;
    if (tick_overrun !== 1'b0) begin
      miss_n++;
      $display("FAIL overrun_clear: got %b, required 0", tick_overrun);
    end
  endtask

  task automatic test_reset_midflight();
    int base, aw0, n;
    w_lat = 4;
    sync_idle("midreset");
    base = log_n;
    cfg(0, 100, 0);
    n = 0;
    while (awvalid !== 1'b1 && n < 3 * TDIV) begin step(); n++; end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    vec_n++;
    if ({awvalid, wvalid, bready, busy} !== 4'b0 || awaddr !== 32'h0 || wdata !== 32'h0) begin
      miss_n++;
      $display("FAIL midreset_outputs: valid/ready/busy=%b addr=%h data=%h, required 0",
               {awvalid, wvalid, bready, busy}, awaddr, wdata);
    end
    w_lat = 0;
    step();
    step();
    rst_n = 1'b1;
    aw0 = aw_hs_n;
    repeat (4 * TDIV) step();
    vec_n++;
    if (log_n !== base || aw_hs_n !== aw0) begin
      miss_n++;
      $display("FAIL midreset_quiet: b=%0d aw=%0d, required 0/0", log_n - base, aw_hs_n - aw0);
    end
    sync_idle("midreset_cfg");
    cfg(0, 20, 0);
    wait_log("midreset_rewrite", base + 1, 3 * TDIV);
    repeat (2 * TDIV) step();
    vec_n++;
    if (log_n !== base + 1 || log_addr[base] !== BASE || log_data[base] !== 32'd20) begin
      miss_n++;
      $display("FAIL midreset_rewrite: writes=%0d addr=%h data=%0d, required 1/%h/20",
               log_n - base, log_addr[base], log_data[base], BASE);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_jump_down();
    test_w_delay();
    test_bresp_err();
    test_overrun();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
